drm_sdpram_clr: RTL
===================

// Module: drm_sdpram_clr
// PURPOSE
//  Single-clock simple-dual-port block RAM with per-byte write enables, a read-valid strobe and an
//  optional output register. A built-in clear sequencer fills every word with CLR_VALUE after
//  reset or on request. Next-generation replacement for the fixed-size DRM wrappers; one instance
//  serves any depth, width and latency.
// PARAMETERS
//  ADDR_WIDTH    14   address bits; DEPTH = 2**ADDR_WIDTH words
//  DATA_WIDTH    32   word width; must be a multiple of BYTE_SIZE
//  BYTE_SIZE     8    bits per byte lane (8 or 9); BE_WIDTH = DATA_WIDTH/BYTE_SIZE (localparam)
//  OUTPUT_REG    0    0: read latency 1; 1: extra output register, read latency 2
//  CLR_ON_RESET  1    1: clear sequence runs automatically when rst_n is released
//  CLR_VALUE     0    DATA_WIDTH-bit word written to every address during a clear
// PORTS
//  clk         in   1           single clock; all logic on rising edge
//  rst_n       in   1           asynchronous, active-low reset
//  clr_req     in   1           pulse: start a full-memory clear (honoured in IDLE only)
//  clr_busy    out  1           high while the clear sequence owns the RAM
//  wr_en       in   1           write strobe
//  wr_addr     in   ADDR_WIDTH  write address
//  wr_data     in   DATA_WIDTH  write data
//  wr_byte_en  in   BE_WIDTH    per-lane write enable; lane i = wr_data[i*BYTE_SIZE +: BYTE_SIZE]
//  rd_en       in   1           read strobe
//  rd_addr     in   ADDR_WIDTH  read address
//  rd_data     out  DATA_WIDTH  read data; holds the last value between reads
//  rd_valid    out  1           one-cycle pulse, aligned with new rd_data
// BEHAVIOUR
//  - Reset values: rd_data=0, rd_valid=0, output pipe cleared, clr_busy=CLR_ON_RESET,
//    clear counter=0, state=CLEAR if CLR_ON_RESET else IDLE. RAM contents are not reset by rst_n.
//  - FSM IDLE->CLEAR: on clr_req=1 in IDLE; clr_busy rises the next cycle.
//  - FSM CLEAR: writes CLR_VALUE to address cnt with all lanes enabled, then cnt+1, one word per
//    cycle. After address DEPTH-1 is written, the FSM returns to IDLE: clr_busy falls on the next
//    edge, exactly DEPTH cycles after it rose. The counter wraps to 0.
//  - clr_req in CLEAR is ignored; there is no restart and no queueing.
//  - While clr_busy=1, user wr_en and rd_en are dropped. No write occurs and no rd_valid is
//    issued. A read already in the output pipe when a clear starts still completes.
//  - rst_n asserted mid-clear aborts the clear. On release it restarts from address 0 if
//    CLR_ON_RESET, else goes to IDLE, leaving a partially cleared RAM.
//  - Write: mem[wr_addr] lane i <= wr_data lane i when wr_en && wr_byte_en[i] && !clr_busy.
//    wr_byte_en=0 with wr_en=1 is a legal no-op.
//  - Read: rd_en sampled at edge N. With OUTPUT_REG=0, rd_data and rd_valid update at N+1. With
//    OUTPUT_REG=1 they update at N+2. Back-to-back reads give one result per cycle, no bubbles.
//  - Same-cycle read and write of the same address, macro absent: read-first (old word returned).
//  - Different-address read and write in the same cycle are fully independent.
//  - Out-of-range conditions are impossible; addresses use the full power-of-two space.
// CONFIGURATION
//  - DRM_SDP_BYPASS_EN defined: a same-address read/write collision returns a merged word. Lanes
//    with wr_byte_en=1 take the new wr_data; other lanes take the old contents. Latency unchanged.
//  - DRM_SDP_BYPASS_EN undefined: read-first as stated above; no bypass muxing is synthesised.
// TESTING
//  1 ADDR_WIDTH=4, CLR_ON_RESET=1, CLR_VALUE=32'hDEADBEEF; release rst_n -> clr_busy high exactly
//    16 cycles; then reading each of addr 0..15 -> 32'hDEADBEEF with rd_valid 1 cycle after rd_en.
//  2 After clear to 0: write addr 5 = 32'hAABBCCDD, be=4'b0101; read addr 5 -> 32'h00BB00DD;
//    write be=4'b0000 to addr 5 -> content unchanged.
//  3 addr 7 holds 32'h11111111; same cycle write 32'h22222222 be=4'b0011 and read addr 7
//    -> without macro 32'h11111111; with DRM_SDP_BYPASS_EN 32'h11112222.
//  4 OUTPUT_REG=1; rd_en on 4 consecutive cycles, addr 0..3 -> 4 consecutive rd_valid pulses
//    starting 2 cycles after the first rd_en, with matching data.
//  5 clr_req while streaming writes -> writes during clr_busy are lost (readback=CLR_VALUE);
//    a second clr_req mid-clear does not lengthen busy beyond DEPTH cycles.
//  6 Assert rst_n at clear cycle 6, release -> clr_busy again lasts a full DEPTH cycles;
//    rd_data=0 and rd_valid=0 throughout reset.

Source files
------------

// File: rtl/drm_sdpram_clr.sv
// ----------------------------------------------------------------------------
// drm_sdpram_clr
//   Single-clock simple-dual-port RAM with per-byte write enables, a read-valid
//   strobe and an optional output register. A built-in clear sequencer writes
//   CLR_VALUE to every word after reset (CLR_ON_RESET) or on clr_req.
//
//   Optional feature macro: DRM_SDP_BYPASS_EN
//     defined   : same-address read/write returns the merged (new lanes + old
//                 lanes) word
//     undefined : read-first, old word returned; no bypass logic
//
// Ports
//   clk         single clock, rising edge
//   rst_n       asynchronous active-low reset (RAM contents are not reset)
//   clr_req     start a full-memory clear (honoured only when idle)
//   clr_busy    high while the clear sequence owns the RAM
//   wr_en       write strobe (dropped while clr_busy)
//   wr_addr     write address
//   wr_data     write data
//   wr_byte_en  per-lane write enable, lane i = wr_data[i*BYTE_SIZE +: BYTE_SIZE]
//   rd_en       read strobe (dropped while clr_busy)
//   rd_addr     read address
//   rd_data     read data, holds last value between reads
//   rd_valid    one-cycle pulse aligned with new rd_data
// ----------------------------------------------------------------------------
module drm_sdpram_clr #(
    parameter int                    ADDR_WIDTH   = 14,
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    BYTE_SIZE    = 8,
    parameter int                    OUTPUT_REG   = 0,
    parameter int                    CLR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE    = '0,
    localparam int                   BE_WIDTH     = DATA_WIDTH / BYTE_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_req,
    output logic                  clr_busy,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BE_WIDTH-1:0]   wr_byte_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic                    wr_ok;
    logic                    rd_ok;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   data1;
    logic                    valid1;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (CLR_ON_RESET != 0) ? S_CLEAR : S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            // Counter wraps to 0 after the last address, ready for the next clear.
            if (state == S_CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (clr_req)    state_nxt = S_CLEAR;
            S_CLEAR: if (cnt == '1)  state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    assign clr_busy = (state == S_CLEAR);
    assign wr_ok    = wr_en && !clr_busy;
    assign rd_ok    = rd_en && !clr_busy;

    // ------------------------------------------------------------------
    // RAM array (no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr_busy) begin
            mem[cnt] <= CLR_VALUE;
        end else if (wr_en) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (wr_byte_en[i])
                    mem[wr_addr][i*BYTE_SIZE +: BYTE_SIZE] <= wr_data[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end

`ifdef DRM_SDP_BYPASS_EN
    // Collision: enabled lanes forward the incoming write data, others keep old.
    always_comb begin
        rd_word = mem[rd_addr];
        if (wr_ok && (wr_addr == rd_addr)) begin
            for (int unsigned i = 0; i < BE_WIDTH; i++) begin
                if (wr_byte_en[i])
                    rd_word[i*BYTE_SIZE +: BYTE_SIZE] = wr_data[i*BYTE_SIZE +: BYTE_SIZE];
            end
        end
    end
`else
    // Read-first: the array update is non-blocking, so the old word is read.
    always_comb begin
        rd_word = mem[rd_addr];
    end
`endif

    // ------------------------------------------------------------------
    // Read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data1  <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= rd_ok;
            if (rd_ok)
                data1 <= rd_word;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] data2;
            logic                  valid2;

            // Stage 2 ignores clr_busy so a read already in flight completes.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data2  <= '0;
                    valid2 <= 1'b0;
                end else begin
                    valid2 <= valid1;
                    if (valid1)
                        data2 <= data1;
                end
            end

            assign rd_data  = data2;
            assign rd_valid = valid2;
        end else begin : g_noreg
            assign rd_data  = data1;
            assign rd_valid = valid1;
        end
    endgenerate

endmodule
